key_light_fader: RTL and testbench
==================================

// Module: key_light_fader
// PURPOSE
//  Drives the twelve RGB LED sub-channels from keyboard key codes, one channel per note.
//  Each note C..B has an LED level that jumps to full brightness when its key strikes.
//  The level then decays linearly over time, so several notes can glow at once.
//  Brightness is rendered by PWM.
//  Sits between the keyboard/UART byte receiver and the board LED pins.
// PARAMETERS
//  C_CLK_FRQ    100000000  clock frequency [Hz]
//  C_PWM_BITS   8          level/PWM resolution; full level LMAX = 2^C_PWM_BITS-1
//  C_STEP_MS    4          decay step interval [ms]; tick period = C_CLK_FRQ/1000*C_STEP_MS cycles
//  C_STEP_SIZE  1          level decrement per tick (1..LMAX)
// PORTS
//  clk        in   1   master clock
//  rst        in   1   reset, asynchronous, active-high
//  inKey      in   8   ASCII key code, sampled only when inValid=1
//  inValid    in   1   one-cycle strobe: inKey holds a new key strike
//  outLED     out  12  PWM LED drive, bit i = note i (0=C ... 11=B), 3 bits per RGB LED
//  outActive  out  1   1 while any channel level != 0
//  outMiss    out  1   one-cycle pulse: strobed key is not a note key
// BEHAVIOUR
//  - Key map, 0x.. -> channel:
//      7A z->0, 73 s->1, 78 x->2, 64 d->3, 63 c->4, 76 v->5
//      67 g->6, 62 b->7, 68 h->8, 6E n->9, 6A j->10, 6D m->11
//    Every other code is unmapped.
//  - Reset (async assert, sync release):
//    all levels=0, tick counter=0, PWM counter=0, outLED=0, outActive=0, outMiss=0.
//    Reset mid-fade kills every LED immediately.
//  - Tick: the counter runs 0..TP-1 and wraps. tick=1 for exactly one cycle at the wrap.
//  - PWM: a free-running C_PWM_BITS counter p wraps LMAX->0.
//    outLED[i] is registered: outLED[i] <= (p < level[i]).
//    level 0 is always dark; LMAX gives duty LMAX/2^C_PWM_BITS.
//  - Strike: an edge with inValid=1 and a mapped key sets level[ch] <= LMAX at that edge.
//    A retrigger while the channel is glowing reloads LMAX.
//  - Decay: on an edge with tick=1, every level != 0 and not loaded that edge becomes
//    max(level - C_STEP_SIZE, 0). Saturating, never wraps below 0.
//  - Simultaneous strike and tick on the same channel: the load wins (LMAX).
//    Other channels still decay.
//  - Unmapped key: outMiss=1 for the single cycle after the strobe edge; levels untouched.
//  - Latency: strobe at edge k -> level loaded at edge k -> outLED[ch] registered at edge k+1,
//    high whenever p<LMAX, i.e. on every cycle except when p == LMAX.
//  - outActive is registered: = |(level != 0), one cycle behind the levels.
//  - The block is polyphonic; strobes on consecutive cycles are all accepted, with no back-pressure.
// STRUCTURE
//  - Package key_light_pkg: C_NUM_NOTES=12, the 12 key-code localparams, and function
//    key2note(inKey) -> {hit, idx[3:0]}.
//  - Sub-module tick_gen (params C_CLK_FRQ, C_STEP_MS): one-cycle tick output, shared with
//    other timed blocks.
//  - Top: 12x level registers, a generate loop of decay/load and compare, PWM counter.
// TESTING
//  Bench parameters: C_CLK_FRQ=100000, C_STEP_MS=1 (TP=100), C_PWM_BITS=4 (LMAX=15),
//  C_STEP_SIZE=1.
//  1) Strobe 0x7A -> level[0]=15; outLED[0] high 15 of every 16 cycles.
//     After 15 ticks (~1500 cycles) it is dark; outActive falls one cycle after level hits 0.
//  2) Strobe 0x6D, then 0x41 -> outLED[11] glows.
//     0x41 gives outMiss high for exactly 1 cycle; all levels unchanged.
//  3) Strobe 0x78; after 5 ticks level[2]=10.
//     Strobe 0x78 again -> level[2]=15, then decays from 15.
//  4) Strobe 0x63 on the cycle tick=1 while level[5]=7 -> level[4]=15, level[5]=6.
//  5) Strobes 0x63, 0x76 on consecutive cycles -> level[4]=level[5]=15, both LEDs PWM in phase.
//  6) Assert rst asynchronously mid-fade (between clk edges) -> outLED=0 and outActive=0
//     before the next edge. After release, no LED lights until a new strobe.

Source files
------------

// File: rtl/key_light_fader_pkg.sv
// Shared definitions for the key-driven LED fader: note count, key codes
// of the twelve note keys and the key-code to note-channel decoder.
package key_light_pkg;

    localparam int C_NUM_NOTES = 12;

    // ASCII key codes of the note keys, lowest note (C) first
    localparam logic [7:0] KEY_C  = 8'h7A; // z
    localparam logic [7:0] KEY_CS = 8'h73; // s
    localparam logic [7:0] KEY_D  = 8'h78; // x
    localparam logic [7:0] KEY_DS = 8'h64; // d
    localparam logic [7:0] KEY_E  = 8'h63; // c
    localparam logic [7:0] KEY_F  = 8'h76; // v
    localparam logic [7:0] KEY_FS = 8'h67; // g
    localparam logic [7:0] KEY_G  = 8'h62; // b
    localparam logic [7:0] KEY_GS = 8'h68; // h
    localparam logic [7:0] KEY_A  = 8'h6E; // n
    localparam logic [7:0] KEY_AS = 8'h6A; // j
    localparam logic [7:0] KEY_B  = 8'h6D; // m

    // Result of decoding one key code
    typedef struct packed {
        logic       hit;   // key code belongs to a note
        logic [3:0] idx;   // note channel 0..11, valid only when hit=1
    } noteSel_t;

    // Map an ASCII key code to its note channel; unmapped codes give hit=0.
    function automatic noteSel_t key2note(input logic [7:0] inKey);
        noteSel_t sel;
        sel.hit = 1'b1;
        sel.idx = 4'd0;
        case (inKey)
            KEY_C:   sel.idx = 4'd0;
            KEY_CS:  sel.idx = 4'd1;
            KEY_D:   sel.idx = 4'd2;
            KEY_DS:  sel.idx = 4'd3;
            KEY_E:   sel.idx = 4'd4;
            KEY_F:   sel.idx = 4'd5;
            KEY_FS:  sel.idx = 4'd6;
            KEY_G:   sel.idx = 4'd7;
            KEY_GS:  sel.idx = 4'd8;
            KEY_A:   sel.idx = 4'd9;
            KEY_AS:  sel.idx = 4'd10;
            KEY_B:   sel.idx = 4'd11;
            default: begin
                sel.hit = 1'b0;
                sel.idx = 4'd0;
            end
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/key_light_fader_tick_gen.sv
// Periodic one-cycle tick generator. The counter runs 0..TP-1 and wraps;
// outTick is high during the cycle in which the counter holds TP-1, so the
// edge that wraps the counter is the edge that consumes the tick.
module tick_gen #(
    parameter int C_CLK_FRQ = 100000000,
    parameter int C_STEP_MS = 4
) (
    input  logic clk,
    input  logic rst,
    output logic outTick
);

    localparam int TP = C_CLK_FRQ / 1000 * C_STEP_MS;
    localparam int CW = (TP > 2) ? $clog2(TP) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TP - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(TP - 2);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [CW-1:0] tickCnt;

    // Period counter plus registered tick, raised one step ahead of the wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tickCnt <= CNT_ZERO;
            outTick <= 1'b0;
        end else begin
            if (tickCnt == CNT_LAST) begin
                tickCnt <= CNT_ZERO;
            end else begin
                tickCnt <= tickCnt + CNT_ONE;
            end
            outTick <= (tickCnt == CNT_PRE);
        end
    end

endmodule

// File: rtl/key_light_fader.sv
// Key-light fader: each of the twelve note channels jumps to full level on
// a key strike and decays linearly on every tick; levels are rendered on
// the LED pins by a shared free-running PWM counter.
module key_light_fader
    import key_light_pkg::*;
#(
    parameter int C_CLK_FRQ   = 100000000,
    parameter int C_PWM_BITS  = 8,
    parameter int C_STEP_MS   = 4,
    parameter int C_STEP_SIZE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             inKey,
    input  logic                   inValid,
    output logic [C_NUM_NOTES-1:0] outLED,
    output logic                   outActive,
    output logic                   outMiss
);

    localparam int LMAX_I = (1 << C_PWM_BITS) - 1;
    localparam logic [C_PWM_BITS-1:0] LMAX    = LMAX_I[C_PWM_BITS-1:0];
    localparam logic [C_PWM_BITS-1:0] LSTEP   = C_STEP_SIZE[C_PWM_BITS-1:0];
    localparam logic [C_PWM_BITS-1:0] LZERO   = {C_PWM_BITS{1'b0}};
    localparam logic [C_PWM_BITS-1:0] PWM_ONE = C_PWM_BITS'(1);

    logic                   tick;
    noteSel_t               noteSel;
    logic                   strike;
    logic                   missNext;
    logic [C_PWM_BITS-1:0]  pwmCnt;
    logic [C_NUM_NOTES-1:0] pwmOn;
    logic [C_NUM_NOTES-1:0] levelNz;

    tick_gen #(
        .C_CLK_FRQ (C_CLK_FRQ),
        .C_STEP_MS (C_STEP_MS)
    ) uTickGen (
        .clk     (clk),
        .rst     (rst),
        .outTick (tick)
    );

    // Decode the strobed key into a note strike or a miss
    always_comb begin
        noteSel  = key2note(inKey);
        if (inValid) begin
            strike   = noteSel.hit;
            missNext = ~noteSel.hit;
        end else begin
            strike   = 1'b0;
            missNext = 1'b0;
        end
    end

    // Free-running PWM phase counter shared by all channels (wraps LMAX->0)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwmCnt <= LZERO;
        end else begin
            pwmCnt <= pwmCnt + PWM_ONE;
        end
    end

    for (genvar g = 0; g < C_NUM_NOTES; g++) begin : gNote
        logic                  load;
        logic [C_PWM_BITS-1:0] levelReg;

        assign load       = strike && (noteSel.idx == 4'(g));
        assign levelNz[g] = (levelReg != LZERO);
        assign pwmOn[g]   = (pwmCnt < levelReg);

        // Channel level: a strike reloads full scale and beats a same-edge
        // tick; otherwise a tick decays the level, saturating at zero
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                levelReg <= LZERO;
            end else if (load) begin
                levelReg <= LMAX;
            end else if (tick && (levelReg != LZERO)) begin
                if (levelReg > LSTEP) begin
                    levelReg <= levelReg - LSTEP;
                end else begin
                    levelReg <= LZERO;
                end
            end
        end
    end

    // Registered LED drive, activity flag and miss pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outLED    <= {C_NUM_NOTES{1'b0}};
            outActive <= 1'b0;
            outMiss   <= 1'b0;
        end else begin
            outLED    <= pwmOn;
            outActive <= |levelNz;
            outMiss   <= missNext;
        end
    end

endmodule

// File: tb/tb_key_light_fader.sv
// Self-checking bench for key_light_fader: directed scenarios plus a random
// phase, every cycle compared against a behavioural model of the levels.
module tb_key_light_fader;

    localparam int TP   = 100;  // tick period in cycles (100 kHz, 1 ms)
    localparam int LMAX = 15;
    localparam int NP   = 16;   // PWM period

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  inKey = 8'h00;
    logic        inValid = 1'b0;
    logic [11:0] outLED;
    logic        outActive;
    logic        outMiss;

    int checks = 0;
    int errors = 0;

    // model state: levels, edges since reset release
    int    lvl [12];
    int    edgeCnt = 0;
    string keyMap = "zsxdcvgbhnjm";

    key_light_fader #(
        .C_CLK_FRQ   (100000),
        .C_PWM_BITS  (4),
        .C_STEP_MS   (1),
        .C_STEP_SIZE (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .inKey     (inKey),
        .inValid   (inValid),
        .outLED    (outLED),
        .outActive (outActive),
        .outMiss   (outMiss)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int keyToCh(input logic [7:0] k);
        for (int i = 0; i < 12; i++) begin
            if (k == keyMap[i]) return i;
        end
        return -1;
    endfunction

    // one clock cycle with given strobe; compares all outputs with the model
    task automatic cycle(input logic v, input logic [7:0] k);
        logic [11:0] expLed;
        logic        expAct;
        logic        expMiss;
        int          ch;
        ch      = v ? keyToCh(k) : -1;
        expAct  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            expLed[i] = ((edgeCnt % NP) < lvl[i]);
            if (lvl[i] != 0) expAct = 1'b1;
        end
        expMiss = v && (ch < 0);
        inValid = v;
        inKey   = k;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        edgeCnt++;
        for (int i = 0; i < 12; i++) begin
            if (i == ch) lvl[i] = LMAX;
            else if ((edgeCnt % TP == 0) && (lvl[i] > 0)) lvl[i] = lvl[i] - 1;
        end
        checkVal("outputs", {18'd0, outMiss, outActive, outLED}, {18'd0, expMiss, expAct, expLed});
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 8'h00);
    endtask

    task automatic idleUntil(input int ph);
        while (edgeCnt % TP != ph) cycle(1'b0, 8'h00);
    endtask

    task automatic countHigh(input int ch, output int n);
        n = 0;
        repeat (NP) begin
            cycle(1'b0, 8'h00);
            n += int'(outLED[ch]);
        end
    endtask

    // asynchronous reset asserted now, released between edges two cycles later
    task automatic doReset();
        rst = 1'b1;
        #1;
        checkVal("rst_async", {19'd0, outMiss, outActive, outLED}, 32'd0);
        for (int i = 0; i < 12; i++) lvl[i] = 0;
        edgeCnt = 0;
        repeat (2) @(posedge clk);
        #1;
        checkVal("rst_hold", {19'd0, outMiss, outActive, outLED}, 32'd0);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic       v;
        logic [7:0] k;
        for (int i = 0; i < 12; i++) lvl[i] = 0;
        #2;
        doReset();

        // 1) single strike on C, full duty then fade to dark
        idleUntil(10);
        cycle(1'b1, 8'h7A);
        countHigh(0, n);
        checkVal("c_full_duty", n, 15);
        idle(1600);
        checkVal("c_dark_active", {31'd0, outActive}, 32'd0);
        checkVal("c_dark_led", {31'd0, outLED[0]}, 32'd0);

        // 2) note strike then unmapped key
        cycle(1'b1, 8'h6D);
        cycle(1'b1, 8'h41);
        checkVal("miss_pulse", {31'd0, outMiss}, 32'd1);
        cycle(1'b0, 8'h00);
        checkVal("miss_clear", {31'd0, outMiss}, 32'd0);
        checkVal("b_glows", {31'd0, outActive}, 32'd1);

        // 3) decay by five ticks, then retrigger
        idleUntil(5);
        cycle(1'b1, 8'h78);
        idle(500);
        countHigh(2, n);
        checkVal("d_after5", n, 10);
        cycle(1'b1, 8'h78);
        countHigh(2, n);
        checkVal("d_retrig", n, 15);

        // 4) strike on the tick edge while F sits at 7
        idleUntil(50);
        cycle(1'b1, 8'h76);
        idle(800);
        idleUntil(99);
        cycle(1'b1, 8'h63);
        countHigh(4, n);
        checkVal("e_load_wins", n, 15);
        countHigh(5, n);
        checkVal("f_decays", n, 6);

        // 5) consecutive strobes on E and F, PWM in phase
        idleUntil(20);
        cycle(1'b1, 8'h63);
        cycle(1'b1, 8'h76);
        repeat (NP) begin
            cycle(1'b0, 8'h00);
            checkVal("ef_in_phase", {31'd0, outLED[4]}, {31'd0, outLED[5]});
        end

        // 6) reset mid-fade, between edges
        idle(40);
        #3;
        doReset();
        idle(200);
        checkVal("dark_after_rst", {20'd0, outLED}, 32'd0);
        cycle(1'b1, 8'h7A);
        cycle(1'b0, 8'h00);
        checkVal("relight_after_rst", {31'd0, outActive}, 32'd1);

        // random polyphonic traffic
        repeat (3000) begin
            v = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) < 7) k = keyMap[$urandom_range(0, 11)];
            else k = 8'($urandom_range(0, 255));
            cycle(v, k);
        end
        idle(300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
